rx_window_sequencer: RTL

Acquisition-window scheduler in the AD_CLK domain, ahead of the DDC/receiver datapath. On a start command it clears the sample FIFO, waits a programmable dead time, then opens a train of `ECHO_NUM` receive windows of `WIN_LEN` samples separated by `ECHO_GAP` idle cycles. It tags every gated sample with window and sample indices, so downstream capture and address generation need no counters of their own.

---
 rtl/rx_window_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/rx_window_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rx_window_sequencer                                           |
// | Purpose  : Acquisition-window scheduler in the AD_CLK domain. On START   |
// |            it clears the sample FIFO, waits DEAD_TIME cycles, then opens |
// |            ECHO_NUM windows of WIN_LEN samples separated by ECHO_GAP     |
// |            idle cycles, tagging each gated sample with its indices.      |
// | Ports    : AD_CLK, RESET_N (async, active-low)                           |
// |            START, ABORT             - run control                        |
// |            DEAD_TIME, WIN_LEN,                                           |
// |            ECHO_GAP, ECHO_NUM       - run configuration (latched)        |
// |            ACQ_GATE, SAMPLE_IDX,                                         |
// |            ECHO_IDX                 - sample gate and tags               |
// |            FIFO_ACLR                - FIFO clear (high during reset)     |
// |            BUSY, DONE, CFG_ERR      - status                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rx_window_sequencer #(
  parameter int CNT_W       = 16,
  parameter int ECHO_W      = 8,
  parameter int ACLR_CYCLES = 4
) (
  input  logic              AD_CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic [CNT_W-1:0]  DEAD_TIME,
  input  logic [CNT_W-1:0]  WIN_LEN,
  input  logic [CNT_W-1:0]  ECHO_GAP,
  input  logic [ECHO_W-1:0] ECHO_NUM,
  output logic              ACQ_GATE,
  output logic [CNT_W-1:0]  SAMPLE_IDX,
  output logic [ECHO_W-1:0] ECHO_IDX,
  output logic              FIFO_ACLR,
  output logic              BUSY,
  output logic              DONE,
  output logic              CFG_ERR
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_DEAD   = 3'd2,
    S_WINDOW = 3'd3,
    S_GAP    = 3'd4,
    S_FINISH = 3'd5
  } t_state;

  localparam logic [CNT_W-1:0]  c_aclr_last = CNT_W'(ACLR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_cnt_zero  = '0;
  localparam logic [CNT_W-1:0]  c_cnt_one   = CNT_W'(1);
  localparam logic [ECHO_W-1:0] c_echo_zero = '0;
  localparam logic [ECHO_W-1:0] c_echo_one  = ECHO_W'(1);

  t_state            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_dead;
  logic [CNT_W-1:0]  r_win;
  logic [CNT_W-1:0]  r_gap;
  logic [ECHO_W-1:0] r_echo_num;
  logic [ECHO_W-1:0] r_echo_cnt;
  logic [CNT_W-1:0]  r_sample_idx;
  logic [ECHO_W-1:0] r_echo_idx;
  logic              r_acq_gate;
  logic              r_fifo_aclr;
  logic              r_busy;
  logic              r_done;
  logic              r_cfg_err;

  t_state            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ECHO_W-1:0] w_echo_cnt_nxt;
  logic [CNT_W-1:0]  w_sample_nxt;
  logic              w_cfg_err_nxt;
  logic              w_accept;

  // Terminal values are (latched - 1); the latched values are never zero
  // where these are used, so no counter has to reach the latched value.
  logic [CNT_W-1:0]  w_dead_last;
  logic [CNT_W-1:0]  w_win_last;
  logic [CNT_W-1:0]  w_gap_last;
  logic [ECHO_W-1:0] w_echo_last;

  assign w_dead_last = r_dead - c_cnt_one;
  assign w_win_last  = r_win - c_cnt_one;
  assign w_gap_last  = r_gap - c_cnt_one;
  assign w_echo_last = r_echo_num - c_echo_one;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_echo_cnt_nxt = r_echo_cnt;
    w_sample_nxt   = r_sample_idx;
    w_cfg_err_nxt  = r_cfg_err;
    w_accept       = 1'b0;

    if (r_state != S_IDLE && ABORT) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START && !ABORT) begin
            if (WIN_LEN != c_cnt_zero && ECHO_NUM != c_echo_zero) begin
              w_accept       = 1'b1;
              w_cfg_err_nxt  = 1'b0;
              w_state_nxt    = S_CLEAR;
              w_cnt_nxt      = c_cnt_zero;
              w_echo_cnt_nxt = c_echo_zero;
            end else begin
              w_cfg_err_nxt = 1'b1;
            end
          end
        end
        S_CLEAR: begin
          if (r_cnt == c_aclr_last) begin
            w_cnt_nxt = c_cnt_zero;
            if (r_dead == c_cnt_zero) begin
              w_state_nxt  = S_WINDOW;
              w_sample_nxt = c_cnt_zero;
            end else begin
              w_state_nxt = S_DEAD;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        S_DEAD: begin
          if (r_cnt == w_dead_last) begin
            w_state_nxt  = S_WINDOW;
            w_sample_nxt = c_cnt_zero;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        S_WINDOW: begin
          if (r_sample_idx == w_win_last) begin
            if (r_echo_cnt == w_echo_last) begin
              w_state_nxt = S_FINISH;
            end else begin
              w_echo_cnt_nxt = r_echo_cnt + c_echo_one;
              if (r_gap == c_cnt_zero) begin
                // Zero gap: next window starts on the very next sample.
                w_sample_nxt = c_cnt_zero;
              end else begin
                w_state_nxt = S_GAP;
                w_cnt_nxt   = c_cnt_zero;
              end
            end
          end else begin
            w_sample_nxt = r_sample_idx + c_cnt_one;
          end
        end
        S_GAP: begin
          if (r_cnt == w_gap_last) begin
            w_state_nxt  = S_WINDOW;
            w_sample_nxt = c_cnt_zero;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        S_FINISH: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so each one is aligned
  // with the cycle the state machine enters.
  always_ff @(posedge AD_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_dead       <= '0;
      r_win        <= '0;
      r_gap        <= '0;
      r_echo_num   <= '0;
      r_echo_cnt   <= '0;
      r_sample_idx <= '0;
      r_echo_idx   <= '0;
      r_acq_gate   <= 1'b0;
      r_fifo_aclr  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_echo_cnt <= w_echo_cnt_nxt;
      r_cfg_err  <= w_cfg_err_nxt;
      if (w_accept) begin
        r_dead     <= DEAD_TIME;
        r_win      <= WIN_LEN;
        r_gap      <= ECHO_GAP;
        r_echo_num <= ECHO_NUM;
      end
      // Indices only move together with the gate and hold outside windows.
      if (w_state_nxt == S_WINDOW) begin
        r_sample_idx <= w_sample_nxt;
        r_echo_idx   <= w_echo_cnt_nxt;
      end
      r_acq_gate  <= (w_state_nxt == S_WINDOW);
      r_fifo_aclr <= (w_state_nxt == S_CLEAR);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_FINISH);
    end
  end

  assign ACQ_GATE   = r_acq_gate;
  assign SAMPLE_IDX = r_sample_idx;
  assign ECHO_IDX   = r_echo_idx;
  assign FIFO_ACLR  = r_fifo_aclr;
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign CFG_ERR    = r_cfg_err;

endmodule
`default_nettype wire
